// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the round-robin UART transmit arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'b00,
        LAUNCH = 2'b01,
        WAIT   = 2'b10
    } arb_state_t;

    localparam int unsigned CLK_FREQ = 100000000;
    localparam int unsigned GRANT_W  = 3;

endpackage

// File: rtl/uart_tx_arbiter_tx.sv
// Byte-wide UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit.
module uart_tx
    import uart_tx_arbiter_pkg::*;
#(
    parameter logic [16:0] freq = 17'd115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [7:0] d_in,
    output logic       seri_out,
    output logic       done
);

    localparam int unsigned FREQ_I   = freq;
    localparam int unsigned BIT_CLKS = 8 * (CLK_FREQ / (FREQ_I * 8));
    localparam int unsigned CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    logic [9:0]       shreg;
    logic [3:0]       bit_idx;
    logic [CNT_W-1:0] cnt;
    logic             loaded;
    logic             active;

    // The frame is loaded one cycle before the start bit appears on the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '1;
            bit_idx  <= '0;
            cnt      <= '0;
            loaded   <= 1'b0;
            active   <= 1'b0;
            seri_out <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (loaded) begin
                loaded   <= 1'b0;
                active   <= 1'b1;
                cnt      <= '0;
                bit_idx  <= '0;
                seri_out <= shreg[0];
                shreg    <= {1'b1, shreg[9:1]};
            end else if (active) begin
                if (cnt == CNT_W'(BIT_CLKS - 1)) begin
                    cnt <= '0;
                    if (bit_idx == 4'd9) begin
                        active   <= 1'b0;
                        done     <= 1'b1;
                        seri_out <= 1'b1;
                    end else begin
                        bit_idx  <= bit_idx + 4'd1;
                        seri_out <= shreg[0];
                        shreg    <= {1'b1, shreg[9:1]};
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (tx_en) begin
                shreg  <= {1'b1, d_in, 1'b0};
                loaded <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter logic [16:0] freq    = 17'd115200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 seri_out,
    output logic                 busy,
    output logic                 sent,
    output logic [GRANT_W-1:0]   sent_id
);

    localparam int unsigned SUM_W = GRANT_W + 1;

    arb_state_t         state;
    logic [GRANT_W-1:0] rr_ptr;
    logic [GRANT_W-1:0] winner;
    logic [SUM_W-1:0]   rr_sum;
    logic [7:0]         valid_ext;
    logic [63:0]        data_ext;
    logic               any_valid;
    logic               accept_ok;
    logic [7:0]         data_reg;
    logic               tx_en;
    logic               tx_done;

    assign valid_ext = 8'(req_valid);
    assign data_ext  = 64'(req_data);

    // Search rr_ptr+1, rr_ptr+2, ... so the last winner has the lowest priority.
    always_comb begin
        winner    = rr_ptr;
        any_valid = 1'b0;
        rr_sum    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            rr_sum = {1'b0, rr_ptr} + SUM_W'(k);
            if (rr_sum >= SUM_W'(NUM_REQ))
                rr_sum = rr_sum - SUM_W'(NUM_REQ);
            if (!any_valid && valid_ext[rr_sum[GRANT_W-1:0]]) begin
                winner    = rr_sum[GRANT_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

    // No accept in the cycle sent is high, so the next accept follows it.
    assign accept_ok = (state == ARB) && any_valid && !sent;
    assign tx_en     = (state == LAUNCH);

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            req_ready[i] = accept_ok && (winner == GRANT_W'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            rr_ptr   <= GRANT_W'(NUM_REQ - 1);
            grant_id <= '0;
            busy     <= 1'b0;
            sent     <= 1'b0;
            sent_id  <= '0;
            data_reg <= '0;
        end else begin
            sent <= 1'b0;
            case (state)
                ARB: begin
                    if (accept_ok) begin
                        data_reg <= data_ext[{winner, 3'b000} +: 8];
                        grant_id <= winner;
                        rr_ptr   <= winner;
                        busy     <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: state <= WAIT;
                WAIT: begin
                    if (tx_done) begin
                        sent    <= 1'b1;
                        sent_id <= grant_id;
                        busy    <= 1'b0;
                        state   <= ARB;
                    end
                end
                default: begin
                    state <= ARB;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    uart_tx #(.freq(freq)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_en    (tx_en),
        .d_in     (data_reg),
        .seri_out (seri_out),
        .done     (tx_done)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: round-robin model, serial-line decoder and directed/random steps.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int BIT = 864;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0] req_ready;
    logic [2:0]    grant_id;
    logic          seri_out;
    logic          busy;
    logic          sent;
    logic [2:0]    sent_id;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .freq(17'd115200)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .seri_out  (seri_out),
        .busy      (busy),
        .sent      (sent),
        .sent_id   (sent_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: first valid requester after the last grant, modulo NR.
    function automatic int model_winner(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++)
            if (v[(last + k) % NR]) return (last + k) % NR;
        return NR;
    endfunction

    int         model_last = NR - 1;
    bit         model_busy = 0;
    int         exp_id[$];
    logic [7:0] exp_byte[$];
    int         grant_log[$];
    int         sent_count = 0;
    int         cyc = 0;
    int         accept_cyc = 0;
    int         gid_pending = -1;
    bit         in_frame = 0;
    int         frame_start = 0;
    int         off;
    int         w;
    logic [9:0] fbits;
    logic       prev_seri = 1'b1;
    logic [NR-1:0] exp_ready;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            model_last  = NR - 1;
            model_busy  = 0;
            exp_id.delete();
            exp_byte.delete();
            in_frame    = 0;
            gid_pending = -1;
            prev_seri   = 1'b1;
        end else begin
            if (gid_pending >= 0) begin
                chk("grant_id", 32'(grant_id), 32'(gid_pending));
                chk("busy_after_accept", 32'(busy), 1);
                gid_pending = -1;
            end
            w = model_winner(req_valid, model_last);
            exp_ready = (model_busy || w == NR) ? '0 : NR'(1 << w);
            if (req_ready != 0 || exp_ready != 0)
                chk("req_ready", 32'(req_ready), 32'(exp_ready));
            if (exp_ready != 0) begin
                exp_id.push_back(w);
                exp_byte.push_back(req_data[8*w +: 8]);
                grant_log.push_back(w);
                model_last  = w;
                model_busy  = 1;
                accept_cyc  = cyc;
                gid_pending = w;
            end
            if (!in_frame && prev_seri && !seri_out) begin
                in_frame    = 1;
                frame_start = cyc;
                fbits       = '0;
                chk("start_latency", 32'(cyc - accept_cyc), 3);
            end
            if (in_frame) begin
                off = cyc - frame_start;
                if (seri_out !== prev_seri)
                    chk("bit_edge_align", 32'(off % BIT), 0);
                if (off % BIT == BIT / 2)
                    fbits[off / BIT] = seri_out;
                if (off == 9 * BIT + BIT / 2)
                    in_frame = 0;
            end
            if (sent) begin
                chk("sent_expected", 32'(exp_id.size() != 0), 1);
                if (exp_id.size() != 0) begin
                    chk("sent_id", 32'(sent_id), 32'(exp_id[0]));
                    chk("tx_byte", 32'(fbits[8:1]), 32'(exp_byte[0]));
                    chk("frame_start_stop", 32'({fbits[9], fbits[0]}), 32'b10);
                    off = cyc - frame_start;
                    chk("sent_timing", 32'(off >= 10 * BIT && off <= 10 * BIT + 4), 1);
                    chk("busy_at_sent", 32'(busy), 0);
                    void'(exp_id.pop_front());
                    void'(exp_byte.pop_front());
                end
                model_busy = 0;
                sent_count++;
            end
        end
        prev_seri = seri_out;
    end

    logic [NR-1:0] keep = '0;
    bit            scramble = 0;

    task automatic step();
        logic [NR-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) begin
                if (!keep[i]) req_valid[i] = 1'b0;
                if (scramble) req_data[8*i +: 8] = 8'hFF;
                else if (keep[i]) req_data[8*i +: 8] = 8'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = '0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_sent(input int target, input int budget);
        int n = 0;
        while (sent_count < target && n < budget) begin
            step();
            n++;
        end
        chk("sent_timeout", 32'(sent_count >= target), 1);
    endtask

    task automatic wait_grants(input int target, input int budget);
        int n = 0;
        while (grant_log.size() < target && n < budget) begin
            step();
            n++;
        end
        chk("grant_timeout", 32'(grant_log.size() >= target), 1);
    endtask

    int         base;
    int         bad;
    logic [15:0] order;

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        do_reset(3);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_seri_out", 32'(seri_out), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sent", 32'(sent), 0);
        chk("rst_sent_id", 32'(sent_id), 0);

        // Single requester 2 with 0xA5
        grant_log.delete();
        base = sent_count;
        @(posedge clk); #1;
        req_data[23:16] = 8'hA5;
        req_valid[2] = 1'b1;
        wait_sent(base + 1, 9500);
        step();
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_grant_count", 32'(grant_log.size()), 1);
        if (grant_log.size() > 0) chk("t1_grant", 32'(grant_log[0]), 2);

        // All four valid at once, data changed right after each accept
        do_reset(2);
        grant_log.delete();
        base = sent_count;
        scramble = 1;
        req_data = 32'h44332211;
        req_valid = 4'hF;
        wait_sent(base + 4, 4 * 8700 + 100);
        scramble = 0;
        order = '0;
        for (int i = 0; i < grant_log.size() && i < 4; i++)
            order = {order[11:0], 4'(grant_log[i])};
        chk("t2_grant_order", 32'(order), 32'h0123);
        chk("t2_sent_count", 32'(sent_count - base), 4);

        // Fairness: requester 0 always valid, requester 3 arrives during frame 0
        do_reset(2);
        grant_log.delete();
        base = sent_count;
        keep = 4'b0001;
        req_data[7:0] = 8'($urandom_range(0, 255));
        req_valid[0] = 1'b1;
        wait_grants(1, 10);
        repeat ($urandom_range(200, 2000)) step();
        req_data[31:24] = 8'($urandom_range(0, 255));
        req_valid[3] = 1'b1;
        wait_sent(base + 2, 2 * 8700 + 100);
        if (grant_log.size() > 1) chk("t3_fair_grant", 32'(grant_log[1]), 3);
        else chk("t3_fair_grant_count", 32'(grant_log.size()), 2);
        keep = '0;

        // Reset about 4 bit periods into a frame
        do_reset(2);
        grant_log.delete();
        req_data[15:8] = 8'($urandom_range(0, 255));
        req_valid[1] = 1'b1;
        wait_grants(1, 10);
        repeat (4 * BIT) step();
        do_reset(1);
        @(negedge clk);
        chk("t5_seri_after_rst", 32'(seri_out), 1);
        chk("t5_busy_after_rst", 32'(busy), 0);
        base = sent_count;
        repeat (1000) step();
        chk("t5_no_sent_aborted", 32'(sent_count - base), 0);
        grant_log.delete();
        req_data[7:0] = 8'($urandom_range(0, 255));
        req_valid[0] = 1'b1;
        wait_sent(base + 1, 9500);
        if (grant_log.size() > 0) chk("t5_grant_after_rst", 32'(grant_log[0]), 0);

        // Idle line
        repeat (2) step();
        bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (req_ready !== '0 || seri_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("t6_idle_bad_cycles", 32'(bad), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one serial transmit line among NUM_REQ byte producers using round-robin arbitration.
- Contains a single `uart_tx` instance and sequences it: accepts one byte from the winning requester, launches the frame, waits for the frame to finish, then re-arbitrates.
- Sits between on-chip byte sources (status reporters, echo path from `uart_rx`, debug logger) and the board TX pin.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- freq, 115200, baud rate; passed unchanged to the internal `uart_tx` (17-bit, 100 MHz system clock).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte pending.
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i].
- grant_id  out  3  index of the requester whose byte is in flight.
- seri_out  out  1  serial TX line; idle high.
- busy  out  1  high from accept until the frame has completed.
- sent  out  1  one-cycle pulse when a frame has finished.
- sent_id  out  3  requester index of the finished frame; valid while sent=1.

Behaviour:
- Reset values: req_ready=0, grant_id=0, seri_out=1, busy=0, sent=0, sent_id=0, rr_ptr=NUM_REQ-1 (requester 0 wins first). State is ARB. The internal `uart_tx` takes the same rst.
- FSM states: ARB, LAUNCH, WAIT.
- ARB:
  - winner = first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in this state only; all other bits 0. req_ready may depend on req_valid.
  - If any requester is valid:
    - capture req_data[winner] into data_reg;
    - set grant_id=rr_ptr=winner and busy<=1;
    - go to LAUNCH.
  - If no requester is valid, stay in ARB with req_ready all 0.
- LAUNCH:
  - Drive tx_en=1 for exactly one cycle, with tx d_in=data_reg held stable.
  - Go to WAIT.
- WAIT:
  - tx_en=0 and req_ready=0.
  - On tx done=1: pulse sent=1 and set sent_id=grant_id for one cycle; set busy<=0; go to ARB.
  - The next accept can occur in the cycle after sent.
- Fairness:
  - Requester i is skipped at most NUM_REQ-1 times while continuously valid.
  - The requester just granted has the lowest priority in the next ARB cycle.
- Latency and timing:
  - Accept at cycle T; tx_en at T+1; start bit on seri_out from T+3.
  - Bit period = 8*(100e6/(freq*8)) clocks, which is 864 at 115200.
  - Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - sent occurs about 10 bit periods after the start bit begins.
- A requester that drops req_valid while another requester is being served loses nothing; no byte is accepted without a handshake.
- Simultaneous requests are resolved by rr_ptr order only; index does not give static priority.
- A change of req_data in the accept cycle after the handshake does not affect the captured byte.
- Reset mid-frame: the FSM returns to ARB and seri_out returns high within 1 cycle. No sent pulse is generated for the aborted frame, and rr_ptr is reset.
- Any illegal state encoding recovers to ARB with busy=0.
- grant_id width is fixed at 3 bits; upper bits are 0 when NUM_REQ<8.

Decomposition:
- Shared package holds:
  - state encodings: ARB=2'b00, LAUNCH=2'b01, WAIT=2'b10;
  - CLK_FREQ=100000000;
  - GRANT_W=3.
- One sub-module: the existing `uart_tx`, instantiated as `u_tx` with .freq(freq).
- The round-robin next-winner function stays inline; no extra module.

Test Plan:
1. Single requester: after reset, req_valid[2]=1 with byte 0xA5.
   - req_ready[2] pulses once and grant_id=2.
   - seri_out carries 0,1,0,1,0,0,1,0,1,1, each level lasting 864 clocks.
   - sent=1 with sent_id=2; busy low afterwards.
2. All four requesters valid simultaneously with bytes 0x11, 0x22, 0x33, 0x44.
   - Grants occur in order 0,1,2,3.
   - Four frames are sent back-to-back with exactly 4 sent pulses.
3. Fairness: requester 0 held continuously valid; requester 3 raises valid during frame 0.
   - The next grant goes to 3, not 0.
4. Data stability: after the accept, req_data changes to 0xFF.
   - The transmitted byte is still the originally captured value (e.g. 0x3C).
5. Reset mid-frame: assert rst for 1 cycle around 4 bit periods into a frame.
   - seri_out=1, busy=0, no sent pulse.
   - The next request from requester 0 is served normally.
6. Idle: req_valid=0 for 10000 cycles.
   - req_ready=0, seri_out=1, busy=0 throughout.
